data_memory_unit: RTL

- Memory-access unit consuming the memu_* command interface driven by the memory stage.
- Translates byte/half/word loads and stores into word-aligned transactions on a single-port data-memory bus. The bus has no byte strobes.
- Sub-word stores are done as read-modify-write (RMW). Load data is returned right-aligned to the access offset, so the memory stage's sign/zero extension works directly on bits [7:0]/[15:0].
- Handles one command at a time. No internal queueing.

---
 rtl/data_memory_unit_pkg.sv | 53 +++++
 rtl/data_memory_unit.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/data_memory_unit_pkg.sv
// Shared types and the load-align/store-merge datapath helpers for data_memory_unit.
// The helpers are plain functions so the merge/align math lives in one place.
package data_memory_unit_pkg;

  localparam logic [31:0] MASK_B = 32'h0000_00ff;
  localparam logic [31:0] MASK_H = 32'h0000_ffff;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR_REQ,
    ERR
  } memu_state_t;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W
  } memu_size_t;

  function automatic memu_size_t size_from_mask(input logic [31:0] wmask);
    if (wmask == MASK_B) return SZ_B;
    else if (wmask == MASK_H) return SZ_H;
    else return SZ_W;
  endfunction

  function automatic logic is_misaligned(input memu_size_t sz, input logic [1:0] off);
    case (sz)
      SZ_H:    return off[0];
      SZ_W:    return (off != 2'b00);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] load_align(input logic [31:0] word, input logic [1:0] off);
    return word >> {off, 3'b000};
  endfunction

  // Halfword lanes are forced even so an unchecked odd half never shifts past bit 31.
  function automatic logic [31:0] store_merge(input logic [31:0] old_word,
                                              input logic [31:0] wdata,
                                              input memu_size_t  sz,
                                              input logic [1:0]  off);
    logic [31:0] m;
    logic [4:0]  sh;
    m  = (sz == SZ_B) ? MASK_B : MASK_H;
    sh = (sz == SZ_H) ? {off[1], 1'b0, 3'b000} : {off, 3'b000};
    if (sz == SZ_W) return wdata;
    return (old_word & ~(m << sh)) | ((wdata & m) << sh);
  endfunction

endpackage

// File: rtl/data_memory_unit.sv
// Memory-access unit: turns byte/half/word loads and stores into word-aligned
// transactions on a strobe-less single-port bus, using read-modify-write for sub-word stores.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | ready for a command; latches it on start
// RD_REQ  | read request on the bus (load, or first half of RMW)
// RD_WAIT | waiting for rvalid; align load data or form merged word
// WR_REQ  | write request with full word (word store or RMW result)
// ERR     | one-cycle misaligned-store flag, no bus access
module data_memory_unit
  import data_memory_unit_pkg::*;
#(
  parameter int XLEN            = 32,
  parameter bit ERR_WDATA_CHECK = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            memu_cmd_start,
  input  logic            memu_cmd_write,
  output logic            memu_cmd_ready,
  output logic            memu_valid,
  input  logic [XLEN-1:0] memu_addr,
  input  logic [XLEN-1:0] memu_wdata,
  input  logic [XLEN-1:0] memu_wmask,
  output logic [XLEN-1:0] memu_rdata,
  output logic            store_misaligned,
  output logic            dmem_req_valid,
  input  logic            dmem_req_ready,
  output logic            dmem_req_write,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata
);

  memu_state_t     state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  memu_size_t      size_q, size_d;
  logic            write_q, write_d;
  logic            valid_q, valid_d;

  logic       accept;
  memu_size_t cmd_size;
  logic       rsp_fire;

  assign accept   = memu_cmd_start && (state_q == IDLE);
  assign cmd_size = size_from_mask(memu_wmask);
  assign rsp_fire = (state_q == RD_WAIT) && dmem_rvalid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (!memu_cmd_write)
            state_d = RD_REQ;
          else if (ERR_WDATA_CHECK && is_misaligned(cmd_size, memu_addr[1:0]))
            state_d = ERR;
          else if (cmd_size == SZ_W)
            state_d = WR_REQ;
          else
            state_d = RD_REQ;
        end
      end
      RD_REQ:  if (dmem_req_ready) state_d = RD_WAIT;
      RD_WAIT: if (dmem_rvalid) state_d = write_q ? WR_REQ : IDLE;
      WR_REQ:  if (dmem_req_ready) state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    memu_cmd_ready   = 1'b0;
    dmem_req_valid   = 1'b0;
    dmem_req_write   = 1'b0;
    store_misaligned = 1'b0;
    case (state_q)
      IDLE:    memu_cmd_ready = 1'b1;
      RD_REQ:  dmem_req_valid = 1'b1;
      WR_REQ: begin
        dmem_req_valid = 1'b1;
        dmem_req_write = 1'b1;
      end
      ERR:     store_misaligned = 1'b1;
      default: ;
    endcase
  end

  // Command latch, RMW merge (overwrites the latched store data) and load alignment.
  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    write_d = write_q;
    rdata_d = rdata_q;
    valid_d = 1'b0;
    if (accept) begin
      addr_d  = memu_addr;
      wdata_d = memu_wdata;
      size_d  = cmd_size;
      write_d = memu_cmd_write;
    end
    if (rsp_fire) begin
      if (write_q) begin
        wdata_d = store_merge(dmem_rdata, wdata_q, size_q, addr_q[1:0]);
      end else begin
        rdata_d = load_align(dmem_rdata, addr_q[1:0]);
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      size_q  <= SZ_W;
      write_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      size_q  <= size_d;
      write_q <= write_d;
      valid_q <= valid_d;
    end
  end

  assign dmem_addr  = {addr_q[XLEN-1:2], 2'b00};
  assign dmem_wdata = wdata_q;
  assign memu_valid = valid_q;
  assign memu_rdata = rdata_q;

endmodule
